mem_xbar_arb: RTL and testbench
===============================

MEM_XBAR_ARB -- requirements
Module: mem_xbar_arb

Interface
REQ-001 Parameters SHALL be:
- DATA_W, DATA_WIDTH, word width.
- ADDR_W, ADDR_WIDTH, per-bank address width.
- NB, NUM_BANKS, bank count; must be >= 2.
- NCH, 2, DMA channel count; must be >= 1.
- STARVE_MAX, 4, maximum consecutive DMA-over-PE grants per bank.

REQ-002 Localparam BANK_BITS SHALL be $clog2(NB).
REQ-003 Ports SHALL be (name, direction, width, meaning):
- clk  in  1  sole clock; rising edge.
- rst  in  1  asynchronous, active-high reset.
- dma_req  in  [NCH]  channel request.
- dma_we  in  [NCH]  1 = write, 0 = read.
- dma_bank_sel  in  [NCH][BANK_BITS]  target bank.
- dma_addr  in  [NCH][ADDR_W]  local address.
- dma_wdata  in  [NCH][DATA_W]  write data.
- dma_gnt  out  [NCH]  request accepted this cycle.
- dma_rvalid  out  [NCH]  read data valid (1-cycle pulse).
- dma_rdata  out  [NCH][DATA_W]  read data.
- pe_read_en, pe_write_en  in  [NB]  per-bank PE access.
- pe_addr  in  [NB][ADDR_W]  PE address.
- pe_data_in  in  [NB][DATA_W]  PE write data.
- pe_stall  out  [NB]  PE access blocked this cycle.
- bank_en, bank_we  out  [NB]  bank access / write enables.
- bank_addr  out  [NB][ADDR_W]  bank address.
- bank_din  out  [NB][DATA_W]  bank write data.
- bank_data_out  in  [NB][DATA_W]  bank read data; 1-cycle synchronous read.

Function
REQ-004 A transfer SHALL occur in any cycle with dma_req[c] && dma_gnt[c]. Requester holds req and all fields stable until granted; the bench asserts this.
REQ-005 Per bank b, dma_gnt SHALL be combinational: at most one channel granted.
- Candidates: channels with req=1 and bank_sel=b.
- Winner: first candidate found scanning upward from rr_ptr[b], modulo NCH.
REQ-006 On a grant on bank b, rr_ptr[b] SHALL become (winner+1) mod NCH at the next edge; with no grant it holds.
REQ-007 On a DMA-owned bank b:
- bank_en[b]=1; bank_we[b]=dma_we; bank_addr and bank_din come from the winning channel.
- pe_stall[b] = pe_read_en[b] | pe_write_en[b].
REQ-008 On a bank with no DMA grant:
- bank_en = pe_read_en | pe_write_en; bank_we = pe_write_en.
- bank_addr and bank_din pass through from the PE port; pe_stall = 0.
REQ-009 A read granted in cycle N:
- registers the channel and bank; bank_data_out is sampled in N+1.
- dma_rvalid[c]=1 with registered dma_rdata in N+2 only.
REQ-010 Reads SHALL be fully pipelined: one grant per channel per cycle, each producing exactly one rvalid, in order.
REQ-011 Writes SHALL produce no response; dma_rdata holds its last value when rvalid=0.
REQ-012 Independent channels targeting different banks in the same cycle SHALL all be granted.
REQ-013 Channels with no request SHALL never be granted; dma_bank_sel is ignored when dma_req=0.

Reset
REQ-014 Asserting rst SHALL asynchronously clear rr_ptr, the read pipeline, dma_rvalid, dma_rdata and the starve counters to 0.
REQ-015 While rst=1, dma_gnt, bank_en, bank_we and pe_stall SHALL be 0.
REQ-016 Reads in flight when rst asserts SHALL be dropped; no rvalid SHALL follow reset release.
REQ-017 The first grant after reset SHALL favour channel 0 on every bank.

Configuration
REQ-018 Macro MEM_XBAR_STARVE_GUARD_EN defined:
- Per-bank counter run_cnt[b] increments on each cycle where DMA owns b while the PE requests b.
- run_cnt[b] clears in any cycle where there is no grant or no PE request on b.
- When run_cnt[b] == STARVE_MAX, the next cycle suppresses all DMA grants on b. The PE owns b (pe_stall=0) and run_cnt[b] clears.
- Suppressed channels stay pending; rr_ptr is unchanged.
REQ-019 Macro undefined: no counters; DMA has absolute priority and the PE may stall indefinitely.

Verification (NB=4, NCH=2, DATA_W=32)
REQ-020 ch0 write bank2 addr 5 data 0xDEADBEEF -> gnt[0] same cycle, bank_we[2]=1, bank_addr[2]=5; ch0 read of the same location -> rvalid[0] two cycles later, rdata=0xDEADBEEF.
REQ-021 ch0 and ch1 both request bank1 for 6 cycles -> grants alternate ch0,ch1,ch0,ch1,ch0,ch1.
REQ-022 ch0 reads bank0 and ch1 reads bank3 in the same cycle -> both granted; both rvalid at +2 with the respective bank data.
REQ-023 PE writes bank1 while ch0 writes bank1 -> pe_stall[1]=1 and bank1 receives the DMA data; banks 0, 2, 3 pass the PE through with stall=0.
REQ-024 Continuous ch0 requests to bank1 plus PE requests for 20 cycles:
- Macro defined: pattern of 4 DMA grants then 1 PE cycle, repeating.
- Macro undefined: pe_stall[1]=1 for all 20 cycles.
REQ-025 rst pulsed in the cycle after a read grant -> no dma_rvalid afterwards; the next contested grant goes to ch0.

Source files
------------

// File: rtl/mem_xbar_arb_if.sv
// mem_xbar_arb_if
//   Bundles every bus of the memory crossbar arbiter: the DMA channel
//   request/grant/read-return signals, the per-bank PE access port and
//   the per-bank SRAM port. clk and rst are not part of this interface.
//
//   modport slave  : arbiter view (DMA/PE requests and bank read data in;
//                    grants, stalls, read returns and bank controls out)
//   modport master : environment view (the exact mirror of slave)
interface mem_xbar_arb_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8,
  parameter int NB     = 4,
  parameter int NCH    = 2
);
  localparam int BANK_BITS = $clog2(NB);

  // DMA channels
  logic [NCH-1:0]                dma_req;
  logic [NCH-1:0]                dma_we;
  logic [NCH-1:0][BANK_BITS-1:0] dma_bank_sel;
  logic [NCH-1:0][ADDR_W-1:0]    dma_addr;
  logic [NCH-1:0][DATA_W-1:0]    dma_wdata;
  logic [NCH-1:0]                dma_gnt;
  logic [NCH-1:0]                dma_rvalid;
  logic [NCH-1:0][DATA_W-1:0]    dma_rdata;

  // PE port, one per bank
  logic [NB-1:0]                 pe_read_en;
  logic [NB-1:0]                 pe_write_en;
  logic [NB-1:0][ADDR_W-1:0]     pe_addr;
  logic [NB-1:0][DATA_W-1:0]     pe_data_in;
  logic [NB-1:0]                 pe_stall;

  // SRAM bank port, one per bank
  logic [NB-1:0]                 bank_en;
  logic [NB-1:0]                 bank_we;
  logic [NB-1:0][ADDR_W-1:0]     bank_addr;
  logic [NB-1:0][DATA_W-1:0]     bank_din;
  logic [NB-1:0][DATA_W-1:0]     bank_data_out;

  modport slave (
    input  dma_req, dma_we, dma_bank_sel, dma_addr, dma_wdata,
    input  pe_read_en, pe_write_en, pe_addr, pe_data_in,
    input  bank_data_out,
    output dma_gnt, dma_rvalid, dma_rdata,
    output pe_stall,
    output bank_en, bank_we, bank_addr, bank_din
  );

  modport master (
    output dma_req, dma_we, dma_bank_sel, dma_addr, dma_wdata,
    output pe_read_en, pe_write_en, pe_addr, pe_data_in,
    output bank_data_out,
    input  dma_gnt, dma_rvalid, dma_rdata,
    input  pe_stall,
    input  bank_en, bank_we, bank_addr, bank_din
  );
endinterface

// File: rtl/mem_xbar_arb.sv
// mem_xbar_arb
//   Crossbar arbiter between NCH DMA channels and NB single-port SRAM
//   banks that are also used by a per-bank PE port. DMA traffic wins over
//   the PE on a bank; between DMA channels each bank has its own
//   round-robin pointer. DMA reads return two cycles after the grant.
//
//   Ports:
//     clk  - rising-edge clock
//     rst  - asynchronous active-high reset
//     bus  - mem_xbar_arb_if.slave (DMA, PE and bank signals)
//
//   Optional feature: define MEM_XBAR_STARVE_GUARD_EN to bound the number
//   of consecutive DMA-over-PE grants on a bank to STARVE_MAX; after that
//   many the PE is given the bank for one cycle.
module mem_xbar_arb #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 8,
  parameter int NB         = 4,
  parameter int NCH        = 2,
  parameter int STARVE_MAX = 4
) (
  input logic           clk,
  input logic           rst,
  mem_xbar_arb_if.slave bus
);
  localparam int BANK_BITS = $clog2(NB);
  localparam int PTR_W     = (NCH > 1) ? $clog2(NCH) : 1;

  // Elaboration-time parameter sanity checks
  if (NB < 2) begin : g_nb_check
    $error("mem_xbar_arb: NB must be >= 2");
  end
  if (NCH < 1) begin : g_nch_check
    $error("mem_xbar_arb: NCH must be >= 1");
  end
  if (STARVE_MAX < 1) begin : g_starve_check
    $error("mem_xbar_arb: STARVE_MAX must be >= 1");
  end

  logic [NB-1:0][PTR_W-1:0]      rr_ptr;
  logic [NB-1:0][PTR_W-1:0]      win_ch;
  logic [NB-1:0]                 bank_won;
  logic [NB-1:0]                 suppress;
  logic [NB-1:0]                 pe_req;
  logic [NCH-1:0]                gnt;
  logic [NCH-1:0]                rd_pend;
  logic [NCH-1:0][BANK_BITS-1:0] rd_bank;
  logic [NCH-1:0]                rvalid_q;
  logic [NCH-1:0][DATA_W-1:0]    rdata_q;
  int                            cand;

  assign pe_req = bus.pe_read_en | bus.pe_write_en;

  // Per-bank round-robin: scan channels upward from rr_ptr and take the
  // first one requesting this bank. Reset forces "no grant" everywhere.
  always_comb begin
    bank_won = '0;
    win_ch   = '0;
    gnt      = '0;
    cand     = 0;
    if (!rst) begin
      for (int b = 0; b < NB; b++) begin
        for (int i = 0; i < NCH; i++) begin
          cand = (int'(rr_ptr[b]) + i) % NCH;
          if (!bank_won[b] && !suppress[b] && bus.dma_req[cand] &&
              (bus.dma_bank_sel[cand] == BANK_BITS'(b))) begin
            bank_won[b] = 1'b1;
            win_ch[b]   = PTR_W'(cand);
            gnt[cand]   = 1'b1;
          end
        end
      end
    end
  end

  assign bus.dma_gnt = gnt;

  // Bank port steering: the winning DMA channel owns the bank and stalls
  // any PE access; otherwise the PE port passes straight through.
  always_comb begin
    bus.bank_en   = '0;
    bus.bank_we   = '0;
    bus.bank_addr = '0;
    bus.bank_din  = '0;
    bus.pe_stall  = '0;
    for (int b = 0; b < NB; b++) begin
      if (bank_won[b]) begin
        bus.bank_en[b]   = 1'b1;
        bus.bank_we[b]   = bus.dma_we[win_ch[b]];
        bus.bank_addr[b] = bus.dma_addr[win_ch[b]];
        bus.bank_din[b]  = bus.dma_wdata[win_ch[b]];
        bus.pe_stall[b]  = pe_req[b];
      end else begin
        bus.bank_en[b]   = pe_req[b] & ~rst;
        bus.bank_we[b]   = bus.pe_write_en[b] & ~rst;
        bus.bank_addr[b] = bus.pe_addr[b];
        bus.bank_din[b]  = bus.pe_data_in[b];
      end
    end
  end

  // Round-robin pointer moves just past the winner; idle banks hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
    end else begin
      for (int b = 0; b < NB; b++) begin
        if (bank_won[b]) begin
          rr_ptr[b] <= PTR_W'((int'(win_ch[b]) + 1) % NCH);
        end
      end
    end
  end

  // Read return pipeline: stage 1 remembers which bank a channel read
  // (the SRAM is producing the word during that cycle), stage 2 captures
  // the word and raises rvalid. rdata holds between returns.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_pend  <= '0;
      rd_bank  <= '0;
      rvalid_q <= '0;
      rdata_q  <= '0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        rd_pend[c]  <= gnt[c] & ~bus.dma_we[c];
        rvalid_q[c] <= rd_pend[c];
        if (gnt[c] && !bus.dma_we[c]) begin
          rd_bank[c] <= bus.dma_bank_sel[c];
        end
        if (rd_pend[c]) begin
          rdata_q[c] <= bus.bank_data_out[rd_bank[c]];
        end
      end
    end
  end

  assign bus.dma_rvalid = rvalid_q;
  assign bus.dma_rdata  = rdata_q;

`ifdef MEM_XBAR_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  logic [NB-1:0][CNT_W-1:0] run_cnt;

  // A bank whose run counter hit the limit is handed to the PE for a cycle
  always_comb begin
    suppress = '0;
    for (int b = 0; b < NB; b++) begin
      suppress[b] = (run_cnt[b] == CNT_W'(STARVE_MAX));
    end
  end

  // Count consecutive cycles where DMA beat a waiting PE on each bank
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_cnt <= '0;
    end else begin
      for (int b = 0; b < NB; b++) begin
        if (suppress[b] || !bank_won[b] || !pe_req[b]) begin
          run_cnt[b] <= '0;
        end else begin
          run_cnt[b] <= run_cnt[b] + 1'b1;
        end
      end
    end
  end
`else
  assign suppress = '0;
`endif

endmodule

// File: tb/tb_mem_xbar_arb.sv
// tb_mem_xbar_arb
//   Scoreboard bench for mem_xbar_arb (NB=4, NCH=2, DATA_W=32, ADDR_W=4).
//   The stimulus process drives one cycle at a time, evaluates a
//   transaction-level reference model and queues the expected cycle
//   outputs and read returns; a monitor on the falling edge pops and
//   compares. Bank SRAMs are modelled behind the bank port.
module tb_mem_xbar_arb;
  localparam int DATA_W     = 32;
  localparam int ADDR_W     = 4;
  localparam int NB         = 4;
  localparam int NCH        = 2;
  localparam int STARVE_MAX = 4;
  localparam int BANK_BITS  = 2;
  localparam int DEPTH      = 16;
`ifdef MEM_XBAR_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  typedef struct {
    logic              valid;
    logic              we;
    int                bank;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } txn_t;

  typedef struct {
    logic                      rst;
    logic [NCH-1:0]            gnt;
    logic [NB-1:0]             en;
    logic [NB-1:0]             we;
    logic [NB-1:0]             stall;
    logic [NB-1:0][ADDR_W-1:0] addr;
    logic [NB-1:0][DATA_W-1:0] din;
  } cyc_exp_t;

  typedef struct {
    logic [DATA_W-1:0] data;
    int                due;
  } rd_exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_xbar_arb_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NB(NB), .NCH(NCH)) bus ();

  mem_xbar_arb #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NB(NB), .NCH(NCH), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int stall_b1_total = 0;

  // Reference model state
  logic [DATA_W-1:0] ref_mem [NB][DEPTH] = '{default: '0};
  int                ptr [NB];
  int                run [NB];
  txn_t              pend [NCH];
  logic              rst_drv;
  logic [NB-1:0]     pe_re, pe_we;
  logic [NB-1:0][ADDR_W-1:0] pe_a;
  logic [NB-1:0][DATA_W-1:0] pe_d;

  // Scoreboard queues
  cyc_exp_t cq [$];
  rd_exp_t  rq [NCH][$];
  logic [NCH-1:0][DATA_W-1:0] last_rdata;

  // Behavioural SRAM banks: 1-cycle synchronous read, write without output
  logic [DATA_W-1:0] bank_mem [NB][DEPTH] = '{default: '0};
  always @(posedge clk) begin
    for (int b = 0; b < NB; b++) begin
      if (bus.bank_en[b]) begin
        if (bus.bank_we[b]) bank_mem[b][bus.bank_addr[b]] <= bus.bank_din[b];
        else bus.bank_data_out[b] <= bank_mem[b][bus.bank_addr[b]];
      end
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s at cycle %0d: actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic txn_t mk(input logic we, input int bank, input int addr, input logic [DATA_W-1:0] d);
    txn_t t;
    t.valid = 1'b1;
    t.we    = we;
    t.bank  = bank;
    t.addr  = ADDR_W'(addr);
    t.wdata = d;
    return t;
  endfunction

  // Drive one cycle and compute what the arbiter must do in it
  task automatic applyStimulus();
    cyc_exp_t e;
    int w, best, d;
    bit sup, pe_any;
    @(posedge clk);
    #1;
    rst = rst_drv;
    for (int c = 0; c < NCH; c++) begin
      bus.dma_req[c]      = pend[c].valid;
      bus.dma_we[c]       = pend[c].valid ? pend[c].we : 1'($urandom);
      bus.dma_bank_sel[c] = pend[c].valid ? BANK_BITS'(pend[c].bank) : BANK_BITS'($urandom);
      bus.dma_addr[c]     = pend[c].valid ? pend[c].addr : ADDR_W'($urandom);
      bus.dma_wdata[c]    = pend[c].valid ? pend[c].wdata : $urandom;
    end
    bus.pe_read_en  = pe_re;
    bus.pe_write_en = pe_we;
    bus.pe_addr     = pe_a;
    bus.pe_data_in  = pe_d;
    e.rst = rst_drv; e.gnt = '0; e.en = '0; e.we = '0; e.stall = '0; e.addr = '0; e.din = '0;
    if (rst_drv) begin
      for (int b = 0; b < NB; b++) begin ptr[b] = 0; run[b] = 0; end
    end else begin
      for (int b = 0; b < NB; b++) begin
        w = -1;
        best = NCH;
        sup = GUARD && (run[b] == STARVE_MAX);
        pe_any = pe_re[b] | pe_we[b];
        if (!sup) begin
          for (int c = 0; c < NCH; c++) begin
            d = (c - ptr[b] + NCH) % NCH;
            if (pend[c].valid && pend[c].bank == b && d < best) begin best = d; w = c; end
          end
        end
        if (w >= 0) begin
          e.gnt[w] = 1'b1; e.en[b] = 1'b1; e.we[b] = pend[w].we;
          e.addr[b] = pend[w].addr; e.din[b] = pend[w].wdata; e.stall[b] = pe_any;
          if (pend[w].we) ref_mem[b][pend[w].addr] = pend[w].wdata;
          else rq[w].push_back('{data: ref_mem[b][pend[w].addr], due: cyc + 2});
          ptr[b] = (w + 1) % NCH;
        end else begin
          e.en[b] = pe_any; e.we[b] = pe_we[b]; e.addr[b] = pe_a[b]; e.din[b] = pe_d[b];
          if (pe_we[b]) ref_mem[b][pe_a[b]] = pe_d[b];
        end
        if (!sup && w >= 0 && pe_any) run[b] = run[b] + 1;
        else run[b] = 0;
      end
      for (int c = 0; c < NCH; c++) if (e.gnt[c]) pend[c].valid = 1'b0;
    end
    cq.push_back(e);
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus();
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  // Monitor: compare each cycle's outputs and every read return
  always @(negedge clk) begin
    cyc_exp_t e;
    rd_exp_t r;
    if (bus.pe_stall[1] && !rst) stall_b1_total <= stall_b1_total + 1;
    if (cq.size() > 0) begin
      e = cq.pop_front();
      if (e.rst) begin
        for (int c = 0; c < NCH; c++) rq[c].delete();
        last_rdata = '0;
      end
      checkOutput("dma_gnt", 64'(bus.dma_gnt), 64'(e.gnt));
      for (int b = 0; b < NB; b++) begin
        checkOutput($sformatf("bank_en[%0d]", b), 64'(bus.bank_en[b]), 64'(e.en[b]));
        checkOutput($sformatf("bank_we[%0d]", b), 64'(bus.bank_we[b]), 64'(e.we[b]));
        checkOutput($sformatf("pe_stall[%0d]", b), 64'(bus.pe_stall[b]), 64'(e.stall[b]));
        if (!e.rst) begin
          checkOutput($sformatf("bank_addr[%0d]", b), 64'(bus.bank_addr[b]), 64'(e.addr[b]));
          checkOutput($sformatf("bank_din[%0d]", b), 64'(bus.bank_din[b]), 64'(e.din[b]));
        end
      end
    end
    for (int c = 0; c < NCH; c++) begin
      if (bus.dma_rvalid[c]) begin
        if (rq[c].size() == 0) begin
          checkOutput($sformatf("rvalid_unexpected[%0d]", c), 64'(1), 64'(0));
        end else begin
          r = rq[c].pop_front();
          checkOutput($sformatf("rvalid_cycle[%0d]", c), 64'(cyc), 64'(r.due));
          checkOutput($sformatf("rdata[%0d]", c), 64'(bus.dma_rdata[c]), 64'(r.data));
          last_rdata[c] = r.data;
        end
      end else begin
        checkOutput($sformatf("rdata_hold[%0d]", c), 64'(bus.dma_rdata[c]), 64'(last_rdata[c]));
        if (rq[c].size() > 0 && rq[c][0].due <= cyc) begin
          checkOutput($sformatf("rvalid_missing[%0d]", c), 64'(0), 64'(1));
          void'(rq[c].pop_front());
        end
      end
    end
  end

  initial begin
    int s0;
    rst = 1'b1;
    rst_drv = 1'b1;
    last_rdata = '0;
    pe_re = '0; pe_we = '0; pe_a = '0; pe_d = '0;
    bus.dma_req = '0; bus.dma_we = '0; bus.dma_bank_sel = '0; bus.dma_addr = '0; bus.dma_wdata = '0;
    bus.pe_read_en = '0; bus.pe_write_en = '0; bus.pe_addr = '0; bus.pe_data_in = '0;
    for (int c = 0; c < NCH; c++) pend[c] = mk(1'b0, 0, 0, '0);
    for (int c = 0; c < NCH; c++) pend[c].valid = 1'b0;
    for (int b = 0; b < NB; b++) begin ptr[b] = 0; run[b] = 0; end

    $display("[TB] reset phase, requests presented during reset");
    pend[0] = mk(1'b1, 1, 3, 32'h1234_5678);
    pe_we = 4'b1111;
    idleCycles(3);
    pe_we = '0;
    rst_drv = 1'b0;
    idleCycles(3);

    $display("[TB] write then read back through bank 2");
    pend[0] = mk(1'b1, 2, 5, 32'hDEAD_BEEF);
    applyStimulus();
    pend[0] = mk(1'b0, 2, 5, '0);
    applyStimulus();
    idleCycles(3);

    $display("[TB] two channels contending for bank 1");
    for (int i = 0; i < 6; i++) begin
      for (int c = 0; c < NCH; c++)
        if (!pend[c].valid) pend[c] = mk(1'($urandom), 1, int'($urandom_range(DEPTH-1, 0)), $urandom);
      applyStimulus();
    end
    idleCycles(3);

    $display("[TB] parallel reads on different banks");
    pend[0] = mk(1'b1, 0, 3, 32'h1111_0000);
    pend[1] = mk(1'b1, 3, 7, 32'h3333_0000);
    applyStimulus();
    pend[0] = mk(1'b0, 0, 3, '0);
    pend[1] = mk(1'b0, 3, 7, '0);
    applyStimulus();
    idleCycles(3);

    $display("[TB] PE and DMA colliding on bank 1");
    pe_we = 4'b1111;
    for (int b = 0; b < NB; b++) begin pe_a[b] = ADDR_W'(b + 8); pe_d[b] = 32'hA0 + b; end
    pend[0] = mk(1'b1, 1, 2, 32'h0000_CAFE);
    applyStimulus();
    pe_we = '0;
    pend[0] = mk(1'b0, 1, 2, '0);
    pend[1] = mk(1'b0, 0, 8, '0);
    applyStimulus();
    idleCycles(3);

    $display("[TB] sustained DMA pressure against the PE on bank 1");
    settle();
    s0 = stall_b1_total;
    pe_we = 4'b0010;
    pe_a[1] = ADDR_W'(9);
    for (int i = 0; i < 20; i++) begin
      pe_d[1] = $urandom;
      if (!pend[0].valid) pend[0] = mk(1'b1, 1, int'($urandom_range(DEPTH-1, 0)), $urandom);
      applyStimulus();
    end
    settle();
    checkOutput("pe_stall_count_20", 64'(stall_b1_total - s0), GUARD ? 64'(16) : 64'(20));
    pe_we = '0;
    idleCycles(4);

    $display("[TB] reset with a read in flight");
    pend[0] = mk(1'b0, 1, 2, '0);
    applyStimulus();
    rst_drv = 1'b1;
    applyStimulus();
    rst_drv = 1'b0;
    applyStimulus();
    pend[0] = mk(1'b1, 1, 4, 32'h5555_AAAA);
    pend[1] = mk(1'b1, 1, 6, 32'h6666_BBBB);
    applyStimulus();
    idleCycles(5);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 400; i++) begin
      for (int c = 0; c < NCH; c++)
        if (!pend[c].valid && $urandom_range(9, 0) < 6)
          pend[c] = mk(1'($urandom), int'($urandom_range(NB-1, 0)), int'($urandom_range(DEPTH-1, 0)), $urandom);
      for (int b = 0; b < NB; b++) begin
        pe_re[b] = ($urandom_range(9, 0) < 3);
        pe_we[b] = !pe_re[b] && ($urandom_range(9, 0) < 3);
        pe_a[b]  = ADDR_W'($urandom);
        pe_d[b]  = $urandom;
      end
      applyStimulus();
    end
    pe_re = '0;
    pe_we = '0;
    idleCycles(8);
    settle();
    for (int c = 0; c < NCH; c++)
      checkOutput($sformatf("reads_outstanding[%0d]", c), 64'(rq[c].size()), 64'(0));
    checkOutput("cycle_queue_drained", 64'(cq.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Absolute time limit so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL timeout: actual=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
